// File: rtl/uart_move_tx.sv
// Buffered UART transmitter for the inter-board move link: a power-of-two FIFO feeds
// a START/DATA/STOP serializer. Define UART_MOVE_TX_PARITY_EN to add an even parity bit.
module uart_move_tx #(
  parameter int CLK_HZ     = 65_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DIVISOR    = 6771,
  parameter int PKT_LEN    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_in,
  input  logic               rst_in_n,
  input  logic               trigger_in,
  input  logic [PKT_LEN-1:0] val_in,
  output logic               data_out,
  output logic               busy,
  output logic               fifo_full,
  output logic               overflow,
  output logic [2:0]         state_dbg
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PKT_LEN - 1);

  if (DIVISOR < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      BAUD_RATE <= 0 || CLK_HZ < BAUD_RATE) begin : g_bad_cfg
    $error("uart_move_tx: invalid parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [PKT_LEN-1:0] shift_q, shift_d;
  logic               data_out_q, data_out_d;
  logic               overflow_q, overflow_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [PKT_LEN-1:0] mem_q [FIFO_DEPTH];
`ifdef UART_MOVE_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic               fifo_empty;
  logic               fifo_full_w;
  logic               pop;
  logic               push_ok;
  logic               bit_done;
  logic [PKT_LEN-1:0] head;

  // ---------------- FIFO ----------------
  // Push handshake: trigger_in is a one-cycle strobe with val_in valid on the same
  // edge; there is no backpressure, so a push into a full FIFO is dropped and flagged.
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_w = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign push_ok     = trigger_in && (!fifo_full_w || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (trigger_in && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= val_in;
    end
  end

  // ---------------- serializer FSM ----------------
  assign bit_done = (clk_cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    pop        = 1'b0;
`ifdef UART_MOVE_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_done ? '0 : clk_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = head;
`ifdef UART_MOVE_TX_PARITY_EN
          parity_d   = ^head;
`endif
          clk_cnt_d  = '0;
          data_out_d = 1'b0;
          state_d    = S_START;
        end
      end

      S_START: begin
        if (bit_done) begin
          data_out_d = shift_q[0];
          shift_d    = shift_q >> 1;
          bit_cnt_d  = '0;
          state_d    = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_MOVE_TX_PARITY_EN
            data_out_d = parity_q;
            state_d    = S_PARITY;
`else
            data_out_d = 1'b1;
            state_d    = S_STOP;
`endif
          end else begin
            data_out_d = shift_q[0];
            shift_d    = shift_q >> 1;
            bit_cnt_d  = bit_cnt_q + 1'b1;
          end
        end
      end

`ifdef UART_MOVE_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          data_out_d = 1'b1;
          state_d    = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (bit_done) begin
          // Chain straight into the next START so queued moves go out gap-free.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_d    = head;
`ifdef UART_MOVE_TX_PARITY_EN
            parity_d   = ^head;
`endif
            data_out_d = 1'b0;
            state_d    = S_START;
          end else begin
            state_d    = S_IDLE;
          end
        end
      end

      default: begin
        data_out_d = 1'b1;
        clk_cnt_d  = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_out_q <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef UART_MOVE_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef UART_MOVE_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_full = fifo_full_w;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_move_tx.sv
// Directed bench for uart_move_tx at DIVISOR=4: line waveform checked every cycle
// against an expected {busy, line} queue built from hand-derived frames.
module tb_uart_move_tx;

  localparam int DIV   = 4;
  localparam int PKT   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0;
  logic [7:0] val = 8'h00;
  logic       data_out;
  logic       busy;
  logic       fifo_full;
  logic       overflow;
  logic [2:0] state_dbg;

  int total = 0;
  int bad = 0;
  logic [1:0] exp_q[$];  // each entry is {busy, line} for one cycle

  uart_move_tx #(
    .CLK_HZ    (40),
    .BAUD_RATE (10),
    .DIVISOR   (DIV),
    .PKT_LEN   (PKT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in    (clk),
    .rst_in_n  (rst_n),
    .trigger_in(trig),
    .val_in    (val),
    .data_out  (data_out),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver / model tasks ----------------
  task automatic drive_cycle(input logic t, input logic [7:0] v);
    @(posedge clk);
    #1;
    trig = t;
    val  = v;
  endtask

  task automatic add_bit(input logic b);
    repeat (DIV) exp_q.push_back({1'b1, b});
  endtask

  task automatic add_frame(input logic [7:0] v);
    add_bit(1'b0);
    for (int k = 0; k < PKT; k++) add_bit(v[k]);
`ifdef UART_MOVE_TX_PARITY_EN
    add_bit(^v);
`endif
    add_bit(1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    trig  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (data_out !== 1'b1) begin
      bad++; $display("FAIL reset_line: got %b expected 1", data_out);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    total++;
    if (fifo_full !== 1'b0) begin
      bad++; $display("FAIL reset_full: got %b expected 0", fifo_full);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL reset_overflow: got %b expected 0", overflow);
    end
    total++;
    if (state_dbg !== 3'd0) begin
      bad++; $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
  endtask

  task automatic test_single_frame();
    logic [1:0] exp;
    int n;
    exp_q.delete();
    exp_q.push_back(2'b11);  // push landed, serializer starts on the next edge
    add_frame(8'hA5);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    n = exp_q.size();
    drive_cycle(1'b1, 8'hA5);
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'b0, 8'h00);
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if ({busy, data_out} !== exp) begin
        bad++;
        $display("FAIL single_frame cycle %0d: busy,line=%b expected %b", i, {busy, data_out}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    logic [1:0] exp;
    int n;
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03;
    exp_q.delete();
    exp_q.push_back(2'b11);
    for (int f = 0; f < 3; f++) add_frame(vals[f]);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    n = exp_q.size();
    drive_cycle(1'b1, vals[0]);
    for (int i = 0; i < n; i++) begin
      if (i + 1 < 3) drive_cycle(1'b1, vals[i+1]);
      else           drive_cycle(1'b0, 8'h00);
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if ({busy, data_out} !== exp) begin
        bad++;
        $display("FAIL back_to_back cycle %0d: busy,line=%b expected %b", i, {busy, data_out}, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [6];
    logic [1:0] exp;
    int n;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    vals[3] = 8'h44; vals[4] = 8'h55; vals[5] = 8'h66;
    exp_q.delete();
    exp_q.push_back(2'b11);
    for (int f = 0; f < 5; f++) add_frame(vals[f]);  // 8'h66 is dropped
    repeat (3) exp_q.push_back(2'b01);
    n = exp_q.size();
    drive_cycle(1'b1, vals[0]);
    for (int i = 0; i < n; i++) begin
      if (i + 1 < 6) drive_cycle(1'b1, vals[i+1]);
      else           drive_cycle(1'b0, 8'h00);
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if ({busy, data_out} !== exp) begin
        bad++;
        $display("FAIL overflow_line cycle %0d: busy,line=%b expected %b", i, {busy, data_out}, exp);
      end
      if (i == 3) begin
        total++;
        if (fifo_full !== 1'b0) begin
          bad++; $display("FAIL overflow_full3: got %b expected 0", fifo_full);
        end
      end
      if (i == 4) begin
        total++;
        if ({fifo_full, overflow} !== 2'b10) begin
          bad++; $display("FAIL overflow_full4: full,ovf=%b expected 10", {fifo_full, overflow});
        end
      end
      if (i == 5) begin
        total++;
        if ({fifo_full, overflow} !== 2'b11) begin
          bad++; $display("FAIL overflow_drop: full,ovf=%b expected 11", {fifo_full, overflow});
        end
      end
    end
    total++;
    if ({fifo_full, overflow} !== 2'b01) begin
      bad++; $display("FAIL overflow_sticky: full,ovf=%b expected 01", {fifo_full, overflow});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] exp;
    int n;
    exp_q.delete();
    exp_q.push_back(2'b11);
    add_frame(8'h00);
    drive_cycle(1'b1, 8'h00);
    // Sample 17 is the first cycle of data bit 3; reset is taken on the following edge.
    for (int i = 0; i < 18; i++) begin
      drive_cycle(i == 0, 8'h5A);
      if (i == 17) rst_n = 1'b0;
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if ({busy, data_out} !== exp) begin
        bad++;
        $display("FAIL mid_frame_pre cycle %0d: busy,line=%b expected %b", i, {busy, data_out}, exp);
      end
    end
    drive_cycle(1'b0, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, data_out, fifo_full, overflow} !== 4'b0100) begin
      bad++;
      $display("FAIL mid_frame_reset: busy,line,full,ovf=%b expected 0100", {busy, data_out, fifo_full, overflow});
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 8'h00);
      @(negedge clk);
      total++;
      if ({busy, data_out} !== 2'b01) begin
        bad++;
        $display("FAIL mid_frame_idle cycle %0d: busy,line=%b expected 01", i, {busy, data_out});
      end
    end
    exp_q.delete();
    exp_q.push_back(2'b11);
    add_frame(8'h3C);
    exp_q.push_back(2'b01);
    n = exp_q.size();
    drive_cycle(1'b1, 8'h3C);
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'b0, 8'h00);
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if ({busy, data_out} !== exp) begin
        bad++;
        $display("FAIL mid_frame_after cycle %0d: busy,line=%b expected %b", i, {busy, data_out}, exp);
      end
    end
  endtask

`ifdef UART_MOVE_TX_PARITY_EN
  task automatic test_parity();
    logic [1:0] exp;
    int n;
    exp_q.delete();
    exp_q.push_back(2'b11);
    add_frame(8'h07);
    exp_q.push_back(2'b01);
    n = exp_q.size();
    drive_cycle(1'b1, 8'h07);
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'b0, 8'h00);
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if ({busy, data_out} !== exp) begin
        bad++;
        $display("FAIL parity_frame cycle %0d: busy,line=%b expected %b", i, {busy, data_out}, exp);
      end
      if (i == 1 + DIV * (PKT + 1)) begin
        total++;
        if (data_out !== 1'b1) begin
          bad++; $display("FAIL parity_bit: got %b expected 1", data_out);
        end
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
`ifdef UART_MOVE_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
